alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the integer ALU in the riscv_g23 datapath.

---
 rtl/alu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked integer ALU, registered result, iterative MUL/MULHU.
// Define ALU_SEQ_DIVU_EN to build the restoring divider for ops 12/13.
module alu_seq #(
    parameter int          XLEN        = 32,
    parameter logic [31:0] ILLEGAL_VAL = 32'hDEADBEEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] y,
    output logic            zero,
    output logic            err
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ILL = XLEN'(ILLEGAL_VAL);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [SHW-1:0]    cnt;
    logic [3:0]        mop;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] p;
    logic [2*XLEN-1:0] p_nxt;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   nhi;
    logic [XLEN-1:0]   nlo;
    logic [XLEN-1:0]   mres;
    logic [XLEN:0]     msum;
    logic [XLEN-1:0]   sc_y;
    logic              sc_err;
    logic [SHW-1:0]    shamt;
    logic              is_mul;
    logic              is_div;
    logic              multi;
    logic              accept;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    assign shamt  = b[SHW-1:0];
    assign is_mul = (op == 4'd10) || (op == 4'd11);
    assign multi  = is_mul || is_div;

    assign hi = p[2*XLEN-1:XLEN];
    assign lo = p[XLEN-1:0];

    // p = {acc, multiplier}; add multiplicand on lsb, then shift right
    assign msum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);

`ifdef ALU_SEQ_DIVU_EN
    logic [XLEN:0]   rsh;
    logic [XLEN-1:0] rdif;
    logic            ge;
    logic            dv;

    assign is_div = (op == 4'd12) || (op == 4'd13);
    assign dv     = (mop == 4'd12) || (mop == 4'd13);
    // p = {partial remainder, dividend/quotient}; one quotient bit per step
    assign rsh  = {hi, lo[XLEN-1]};
    assign ge   = rsh >= {1'b0, mcand};
    assign rdif = rsh[XLEN-1:0] - mcand;

    always_comb begin
        p_nxt = {msum, lo[XLEN-1:1]};
        if (dv) begin
            if (ge) p_nxt = {rdif, lo[XLEN-2:0], 1'b1};
            else    p_nxt = {rsh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
        end
    end
`else
    assign is_div = 1'b0;
    assign p_nxt  = {msum, lo[XLEN-1:1]};
`endif

    assign nhi  = p_nxt[2*XLEN-1:XLEN];
    assign nlo  = p_nxt[XLEN-1:0];
    assign mres = ((mop == 4'd11) || (mop == 4'd13)) ? nhi : nlo;

    always_comb begin
        sc_y   = ILL;
        sc_err = 1'b1;
        case (op)
            4'd0:  begin sc_y = a + b;  sc_err = 1'b0; end
            4'd1:  begin sc_y = a | b;  sc_err = 1'b0; end
            4'd2:  begin sc_y = a & b;  sc_err = 1'b0; end
            4'd3:  begin sc_y = a << shamt; sc_err = 1'b0; end
            4'd4:  begin sc_y = a - b;  sc_err = 1'b0; end
            4'd5:  begin sc_y = a ^ b;  sc_err = 1'b0; end
            4'd6:  begin sc_y = a >> shamt; sc_err = 1'b0; end
            4'd7:  begin
                sc_y   = $unsigned($signed(a) >>> shamt);
                sc_err = 1'b0;
            end
            4'd8:  begin
                sc_y   = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
                sc_err = 1'b0;
            end
            4'd9:  begin
                sc_y   = {{(XLEN-1){1'b0}}, a < b};
                sc_err = 1'b0;
            end
            4'd15: begin sc_y = b; sc_err = 1'b0; end
            default: begin
                sc_y   = ILL;
                sc_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            mop   <= '0;
            mcand <= '0;
            p     <= '0;
            y     <= '0;
            zero  <= 1'b1;
            err   <= 1'b0;
        end else if (accept) begin
            mop <= op;
            if (multi) begin
                state <= BUSY;
                cnt   <= SHW'(XLEN-1);
                if (is_div) begin
                    p     <= {{XLEN{1'b0}}, a};
                    mcand <= b;
                end else begin
                    p     <= {{XLEN{1'b0}}, b};
                    mcand <= a;
                end
            end else begin
                state <= DONE;
                y     <= sc_y;
                zero  <= (sc_y == '0);
                err   <= sc_err;
            end
        end else if (state == BUSY) begin
            p <= p_nxt;
            if (cnt == '0) begin
                state <= DONE;
                y     <= mres;
                zero  <= (mres == '0);
                err   <= 1'b0;
            end else begin
                cnt <= cnt - SHW'(1);
            end
        end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table over XLEN=16/32/64 instances,
// plus hand sequences for backpressure and reset during a multiply.
`timescale 1ns/1ps
module tb_alu_seq;
    typedef struct {
        int          w;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] y;
        logic        z;
        logic        e;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic        ordy;
    logic [3:0]  top;
    logic [63:0] ta;
    logic [63:0] tbv;
    int          w;

    logic        ir16, ov16, z16, e16;
    logic [15:0] y16;
    logic        ir32, ov32, z32, e32;
    logic [31:0] y32;
    logic        ir64, ov64, z64, e64;
    logic [63:0] y64;

    logic        cir, cov, cz, ce;
    logic [63:0] cy;

    int   checks = 0;
    int   failures = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    alu_seq #(.XLEN(16)) u16 (
        .clk(clk), .rst(rst),
        .in_valid(vld && (w == 16)), .in_ready(ir16),
        .a(ta[15:0]), .b(tbv[15:0]), .op(top),
        .out_valid(ov16), .out_ready(ordy),
        .y(y16), .zero(z16), .err(e16)
    );

    alu_seq #(.XLEN(32)) u32 (
        .clk(clk), .rst(rst),
        .in_valid(vld && (w == 32)), .in_ready(ir32),
        .a(ta[31:0]), .b(tbv[31:0]), .op(top),
        .out_valid(ov32), .out_ready(ordy),
        .y(y32), .zero(z32), .err(e32)
    );

    alu_seq #(.XLEN(64)) u64 (
        .clk(clk), .rst(rst),
        .in_valid(vld && (w == 64)), .in_ready(ir64),
        .a(ta), .b(tbv), .op(top),
        .out_valid(ov64), .out_ready(ordy),
        .y(y64), .zero(z64), .err(e64)
    );

    always_comb begin
        cir = ir32;
        cov = ov32;
        cz  = z32;
        ce  = e32;
        cy  = {32'h0, y32};
        if (w == 16) begin
            cir = ir16;
            cov = ov16;
            cz  = z16;
            ce  = e16;
            cy  = {48'h0, y16};
        end else if (w == 64) begin
            cir = ir64;
            cov = ov64;
            cz  = z64;
            ce  = e64;
            cy  = y64;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic void add(input int wi, input logic [3:0] o,
                                input logic [63:0] av, input logic [63:0] bv,
                                input logic [63:0] yv, input logic zv,
                                input logic ev, input int lv);
        vec_t v;
        v.w = wi; v.op = o; v.a = av; v.b = bv;
        v.y = yv; v.z = zv; v.e = ev; v.lat = lv;
        vq.push_back(v);
    endfunction

    // Accept one op, then count negedges until out_valid (bounded).
    task automatic issue(input logic [3:0] o, input logic [63:0] av,
                         input logic [63:0] bv, output int lat,
                         output int irl);
        int n = 0;
        while (!cir && n < 200) begin
            @(negedge clk);
            n++;
        end
        top = o;
        ta  = av;
        tbv = bv;
        vld = 1'b1;
        @(posedge clk);
        lat = 0;
        irl = 0;
        do begin
            @(negedge clk);
            vld = 1'b0;
            lat++;
            if (!cov && !cir) irl++;
        end while (!cov && lat < 200);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int lat;
        int irl;
        rst = 1'b1; vld = 1'b0; ordy = 1'b1;
        top = '0; ta = '0; tbv = '0; w = 32;

        add(32, 4'd0,  64'd5,        64'd7,        64'd12,       0, 0, 1);
        add(32, 4'd0,  64'hFFFFFFFF, 64'd1,        64'd0,        1, 0, 1);
        add(32, 4'd4,  64'd3,        64'd3,        64'd0,        1, 0, 1);
        add(32, 4'd7,  64'h80000000, 64'h24,       64'hF8000000, 0, 0, 1);
        add(32, 4'd8,  64'hFFFFFFFF, 64'd1,        64'd1,        0, 0, 1);
        add(32, 4'd9,  64'hFFFFFFFF, 64'd1,        64'd0,        1, 0, 1);
        add(32, 4'd1,  64'hF0F0,     64'h0F0F,     64'hFFFF,     0, 0, 1);
        add(32, 4'd2,  64'hFF00FF00, 64'h0FF00FF0, 64'h0F000F00, 0, 0, 1);
        add(32, 4'd3,  64'd1,        64'h21,       64'd2,        0, 0, 1);
        add(32, 4'd5,  64'hAAAA5555, 64'hFFFF0000, 64'h55555555, 0, 0, 1);
        add(32, 4'd6,  64'h80000000, 64'h1F,       64'd1,        0, 0, 1);
        add(32, 4'd15, 64'd0,        64'h1234,     64'h1234,     0, 0, 1);
        add(32, 4'd10, 64'hFFFFFFFF, 64'd2,        64'hFFFFFFFE, 0, 0, 33);
        add(32, 4'd11, 64'hFFFFFFFF, 64'd2,        64'd1,        0, 0, 33);
        add(32, 4'd10, 64'h12345678, 64'h10,       64'h23456780, 0, 0, 33);
        add(32, 4'd10, 64'h10000,    64'h10000,    64'd0,        1, 0, 33);
        add(32, 4'd11, 64'h10000,    64'h10000,    64'd1,        0, 0, 33);
        add(32, 4'd14, 64'd1,        64'd2,        64'hDEADBEEF, 0, 1, 1);
`ifdef ALU_SEQ_DIVU_EN
        add(32, 4'd12, 64'd100,      64'd7,        64'd14,       0, 0, 33);
        add(32, 4'd13, 64'd100,      64'd7,        64'd2,        0, 0, 33);
        add(32, 4'd12, 64'd5,        64'd0,        64'hFFFFFFFF, 0, 0, 33);
        add(32, 4'd13, 64'd9,        64'd0,        64'd9,        0, 0, 33);
`else
        add(32, 4'd12, 64'd100,      64'd7,        64'hDEADBEEF, 0, 1, 1);
        add(32, 4'd13, 64'd100,      64'd7,        64'hDEADBEEF, 0, 1, 1);
`endif
        add(16, 4'd0,  64'd5,        64'd7,        64'd12,       0, 0, 1);
        add(16, 4'd4,  64'd3,        64'd3,        64'd0,        1, 0, 1);
        add(16, 4'd7,  64'h8000,     64'h24,       64'hF800,     0, 0, 1);
        add(16, 4'd8,  64'hFFFF,     64'd1,        64'd1,        0, 0, 1);
        add(16, 4'd9,  64'hFFFF,     64'd1,        64'd0,        1, 0, 1);
        add(16, 4'd10, 64'hFFFF,     64'd2,        64'hFFFE,     0, 0, 17);
        add(16, 4'd11, 64'hFFFF,     64'd2,        64'd1,        0, 0, 17);
        add(16, 4'd14, 64'd0,        64'd0,        64'hBEEF,     0, 1, 1);
        add(64, 4'd0,  64'd5,        64'd7,        64'd12,       0, 0, 1);
        add(64, 4'd4,  64'd3,        64'd3,        64'd0,        1, 0, 1);
        add(64, 4'd7,  64'h8000000000000000, 64'h44,
            64'hF800000000000000, 0, 0, 1);
        add(64, 4'd8,  '1,           64'd1,        64'd1,        0, 0, 1);
        add(64, 4'd9,  '1,           64'd1,        64'd0,        1, 0, 1);
        add(64, 4'd10, '1,           64'd2,
            64'hFFFFFFFFFFFFFFFE, 0, 0, 65);
        add(64, 4'd11, '1,           64'd2,        64'd1,        0, 0, 65);
        add(64, 4'd14, 64'd0,        64'd0,        64'hDEADBEEF, 0, 1, 1);

        repeat (2) @(negedge clk);
        chk("rst_ov",   64'(cov), 64'd0);
        chk("rst_ir",   64'(cir), 64'd1);
        chk("rst_y",    cy,       64'd0);
        chk("rst_zero", 64'(cz),  64'd1);
        chk("rst_err",  64'(ce),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vq[i]) begin
            w = vq[i].w;
            #1;
            issue(vq[i].op, vq[i].a, vq[i].b, lat, irl);
            chk($sformatf("v%0d_w%0d_y", i, w), cy, vq[i].y);
            chk($sformatf("v%0d_zero", i), 64'(cz), 64'(vq[i].z));
            chk($sformatf("v%0d_err", i), 64'(ce), 64'(vq[i].e));
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vq[i].lat));
            chk($sformatf("v%0d_busy", i), 64'(irl), 64'(vq[i].lat - 1));
        end

        w = 32;
        #1;
        ordy = 1'b0;
        issue(4'd0, 64'd1, 64'd2, lat, irl);
        chk("bp_y0", cy, 64'd3);
        for (int k = 0; k < 5; k++) begin
            ta  = 64'hFFFF;
            top = 4'd5;
            @(negedge clk);
            chk($sformatf("bp%0d_ov", k), 64'(cov), 64'd1);
            chk($sformatf("bp%0d_y", k), cy, 64'd3);
            chk($sformatf("bp%0d_ir", k), 64'(cir), 64'd0);
        end
        ordy = 1'b1;
        vld  = 1'b1;
        top  = 4'd0;
        ta   = 64'd10;
        tbv  = 64'd20;
        #1;
        chk("bp_ir_same_cycle", 64'(cir), 64'd1);
        @(negedge clk);
        vld = 1'b0;
        chk("bp_new_ov", 64'(cov), 64'd1);
        chk("bp_new_y", cy, 64'd30);

        @(negedge clk);
        top = 4'd10;
        ta  = 64'd7;
        tbv = 64'd9;
        vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_busy_ir", 64'(cir), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ov",   64'(cov), 64'd0);
        chk("midrst_ir",   64'(cir), 64'd1);
        chk("midrst_y",    cy,       64'd0);
        chk("midrst_zero", 64'(cz),  64'd1);
        issue(4'd0, 64'd2, 64'd2, lat, irl);
        chk("post_rst_y",   cy,        64'd4);
        chk("post_rst_lat", 64'(lat),  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
